// File: rtl/sw_stim_sequencer_if.sv
// Control and status bundle between a stimulus controller and the switch-vector sequencer.
// Latency: none, wires only.
// Backpressure: none; the controller owns the i_* inputs and the sequencer owns the o_* outputs.
interface sw_stim_sequencer_if #(
   parameter int DATA_W  = 32,
   parameter int DWELL_W = 16,
   parameter int CNT_W   = 16
);
   logic               i_start;
   logic               i_stop;
   logic [1:0]         i_mode;
   logic [DWELL_W-1:0] i_dwell;
   logic [CNT_W-1:0]   i_count;
   logic [DATA_W-1:0]  i_init;
   logic [DATA_W-1:0]  o_sw_data;
   logic               o_busy;
   logic               o_done;
   logic               o_update;
   logic [CNT_W-1:0]   o_vec_cnt;

   // Controller side: drives commands, observes the generated vector and status.
   modport master (
      output i_start, i_stop, i_mode, i_dwell, i_count, i_init,
      input  o_sw_data, o_busy, o_done, o_update, o_vec_cnt
   );

   // Sequencer side.
   modport slave (
      input  i_start, i_stop, i_mode, i_dwell, i_count, i_init,
      output o_sw_data, o_busy, o_done, o_update, o_vec_cnt
   );
endinterface

// File: rtl/sw_stim_sequencer.sv
// Programmable switch-vector sequencer: HOLD / INC / WALK / LFSR patterns, each vector held i_dwell+1 cycles.
// Latency: first vector and o_busy appear one cycle after i_start in IDLE; all outputs are registered.
// Backpressure: none; i_stop aborts a run on the next cycle and takes priority over advance and completion.
module sw_stim_sequencer #(
   parameter int          DATA_W    = 32,
   parameter int          DWELL_W   = 16,
   parameter int          CNT_W     = 16,
   parameter logic [31:0] LFSR_TAPS = 32'h8020_0003,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   sw_stim_sequencer_if.slave   sif
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam logic [1:0] M_HOLD = 2'd0;
   localparam logic [1:0] M_INC  = 2'd1;
   localparam logic [1:0] M_WALK = 2'd2;
   localparam logic [1:0] M_LFSR = 2'd3;

   localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);
   localparam logic [DATA_W-1:0] SEED = DATA_W'(LFSR_SEED);

   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
   logic [DATA_W-1:0]  sw_data_q, sw_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               update_q, update_d;

   // WALK needs a one-hot start and LFSR must never start at zero (it would lock up).
   function automatic logic [DATA_W-1:0] first_vec(input logic [1:0] mode, input logic [DATA_W-1:0] init);
      logic [DATA_W-1:0] v;
      v = init;
      if (mode == M_WALK) begin
         if (!((init != '0) && ((init & (init - 1'b1)) == '0))) v = {{(DATA_W-1){1'b0}}, 1'b1};
      end else if (mode == M_LFSR) begin
         if (init == '0) v = SEED;
      end
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] next_vec(input logic [1:0] mode, input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] n;
      case (mode)
         M_HOLD:  n = v;
         M_INC:   n = v + 1'b1;
         M_WALK:  n = {v[DATA_W-2:0], v[DATA_W-1]};
         default: n = (v >> 1) ^ (v[0] ? TAPS : '0);
      endcase
      return n;
   endfunction

   // Next-state and output logic; pulses default low, everything else holds.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      dwell_cfg_d = dwell_cfg_q;
      dwell_cnt_d = dwell_cnt_q;
      count_d     = count_q;
      vec_cnt_d   = vec_cnt_q;
      sw_data_d   = sw_data_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      update_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sif.i_start) begin
               mode_d      = sif.i_mode;
               dwell_cfg_d = sif.i_dwell;
               count_d     = sif.i_count;
               sw_data_d   = first_vec(sif.i_mode, sif.i_init);
               vec_cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
               dwell_cnt_d = sif.i_dwell;
               update_d    = 1'b1;
               busy_d      = 1'b1;
               state_d     = ST_RUN;
            end
         end
         ST_RUN: begin
            if (sif.i_stop) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (dwell_cnt_q != '0) begin
               dwell_cnt_d = dwell_cnt_q - 1'b1;
            end else if ((count_q != '0) && (vec_cnt_q == count_q)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               sw_data_d   = next_vec(mode_q, sw_data_q);
               dwell_cnt_d = dwell_cfg_q;
               update_d    = 1'b1;
               if (vec_cnt_q != '1) vec_cnt_d = vec_cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         mode_q      <= M_HOLD;
         dwell_cfg_q <= '0;
         dwell_cnt_q <= '0;
         count_q     <= '0;
         vec_cnt_q   <= '0;
         sw_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         update_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         dwell_cfg_q <= dwell_cfg_d;
         dwell_cnt_q <= dwell_cnt_d;
         count_q     <= count_d;
         vec_cnt_q   <= vec_cnt_d;
         sw_data_q   <= sw_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         update_q    <= update_d;
      end
   end

   assign sif.o_sw_data = sw_data_q;
   assign sif.o_busy    = busy_q;
   assign sif.o_done    = done_q;
   assign sif.o_update  = update_q;
   assign sif.o_vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_sw_stim_sequencer.sv
// Self-checking bench for sw_stim_sequencer: expected vectors queued at start, popped on each o_update.
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_sw_stim_sequencer;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] sb[$];

   sw_stim_sequencer_if #(.DATA_W(32), .DWELL_W(16), .CNT_W(16)) sif ();

   sw_stim_sequencer #(
      .DATA_W(32), .DWELL_W(16), .CNT_W(16),
      .LFSR_TAPS(32'h8020_0003), .LFSR_SEED(32'hACE1_0001)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .sif     (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_first(input logic [1:0] mode, input logic [31:0] init);
      if (mode == 2'd2) return ($countones(init) == 1) ? init : 32'h1;
      if (mode == 2'd3) return (init != 0) ? init : 32'hACE1_0001;
      return init;
   endfunction

   function automatic logic [31:0] m_next(input logic [1:0] mode, input logic [31:0] v);
      case (mode)
         2'd0:    return v;
         2'd1:    return v + 32'd1;
         2'd2:    return {v[30:0], v[31]};
         default: return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
      endcase
   endfunction

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_data"},   sif.o_sw_data, 0);
      chk({tag, "_busy"},   sif.o_busy,    0);
      chk({tag, "_done"},   sif.o_done,    0);
      chk({tag, "_update"}, sif.o_update,  0);
      chk({tag, "_cnt"},    sif.o_vec_cnt, 0);
   endtask

   // count==0 runs infinitely and is aborted with i_stop right after the stop_after-th vector appears.
   task automatic run_seq(input string tag, input logic [1:0] mode, input logic [31:0] init,
                          input int dwell, input int count, input int stop_after, input bit poke_start);
      int n_vec, exp_busy, budget;
      int busy_c, upd_c, done_c, hold, post;
      bit end_seen;
      logic [31:0] v, last_v;
      n_vec    = (count == 0) ? stop_after : count;
      exp_busy = (count == 0) ? (n_vec - 1) * (dwell + 1) + 1 : n_vec * (dwell + 1);
      budget   = n_vec * (dwell + 1) + 20;
      busy_c = 0; upd_c = 0; done_c = 0; hold = 0; post = 0; end_seen = 0;
      sb.delete();
      v = m_first(mode, init);
      last_v = v;
      for (int i = 0; i < n_vec; i++) begin
         sb.push_back(v);
         last_v = v;
         v = m_next(mode, v);
      end
      sif.i_mode  = mode;
      sif.i_init  = init;
      sif.i_dwell = 16'(dwell);
      sif.i_count = 16'(count);
      sif.i_stop  = 1'b0;
      sif.i_start = 1'b1;
      for (int c = 0; c < budget && post < 4; c++) begin
         @(negedge clk);
         sif.i_start = 1'b0;
         sif.i_stop  = 1'b0;
         if (end_seen) post++;
         if (sif.o_busy) busy_c++;
         if (sif.o_update) begin
            if (hold != 0) chk({tag, "_dwell"}, hold, dwell + 1);
            hold = 1;
            upd_c++;
            if (sb.size() == 0) chk({tag, "_extra_update"}, 1, 0);
            else                chk({tag, "_vec"}, sif.o_sw_data, sb.pop_front());
            if (poke_start && upd_c == 2) begin
               sif.i_start = 1'b1;
               sif.i_mode  = mode + 2'd1;
               sif.i_init  = ~init;
               sif.i_dwell = 16'd7;
            end
            if (count == 0 && upd_c == stop_after) begin
               sif.i_stop = 1'b1;
               end_seen   = 1'b1;
            end
         end else if (sif.o_busy) begin
            hold++;
         end
         if (sif.o_done) begin
            done_c++;
            chk({tag, "_busy_at_done"}, sif.o_busy, 0);
            end_seen = 1'b1;
         end
      end
      if (!end_seen) chk({tag, "_timeout"}, 0, 1);
      chk({tag, "_busy_cycles"}, busy_c, exp_busy);
      chk({tag, "_updates"},     upd_c,  n_vec);
      chk({tag, "_done_pulses"}, done_c, (count != 0) ? 1 : 0);
      chk({tag, "_final_data"},  sif.o_sw_data, last_v);
      chk({tag, "_final_cnt"},   sif.o_vec_cnt, n_vec);
      chk({tag, "_sb_empty"},    sb.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      sif.i_start = 1'b0;
      sif.i_stop  = 1'b0;
      sif.i_mode  = 2'd0;
      sif.i_dwell = '0;
      sif.i_count = '0;
      sif.i_init  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // Idle after reset: stop pulses are ignored and outputs stay at reset values.
      for (int i = 0; i < 5; i++) begin
         sif.i_stop = (i == 2);
         @(negedge clk);
         chk_idle_outputs("reset_idle");
      end
      sif.i_stop = 1'b0;

      run_seq("inc",       2'd1, 32'd5,         2, 4,  0,  1'b0);
      run_seq("inc_wrap",  2'd1, 32'hFFFF_FFFE, 0, 3,  0,  1'b0);
      run_seq("walk",      2'd2, 32'h3,         0, 33, 0,  1'b0);
      run_seq("lfsr_seed", 2'd3, 32'h0,         0, 2,  0,  1'b0);
      run_seq("lfsr",      2'd3, 32'h1234_5679, 1, 6,  0,  1'b0);
      run_seq("hold_poke", 2'd0, 32'hA5,        1, 4,  0,  1'b1);
      run_seq("walk_1hot", 2'd2, 32'h0100_0000, 3, 3,  0,  1'b0);
      run_seq("inf_stop",  2'd1, 32'd100,       1, 0,  10, 1'b0);

      // Reset in the middle of an infinite run.
      sif.i_mode  = 2'd1;
      sif.i_init  = 32'd7;
      sif.i_dwell = 16'd0;
      sif.i_count = 16'd0;
      sif.i_start = 1'b1;
      @(negedge clk);
      sif.i_start = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrun_busy_before", sif.o_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_idle_outputs("midrun_reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle_outputs("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sw_stim_sequencer.md
Name: sw_stim_sequencer

Overview:
Parametrised successor to the fixed switch-stimulus driver. It generates a sequence of vectors on a DATA_W-bit switch bus that drives the core's i_io_sw input. The sequence pattern is selected at run time: hold, increment, walking-one or LFSR. Dwell time per vector and vector count are programmable, with start/stop control and busy/done/update status for the scoreboard.

Parameters:
DATA_W, 32, width of the generated switch vector
DWELL_W, 16, width of the dwell counter
CNT_W, 16, width of the vector count and counter
LFSR_TAPS, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1), truncated to DATA_W
LFSR_SEED, 32'hACE1_0001, substitute seed when LFSR init is zero, truncated to DATA_W, must be nonzero

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start a sequence; sampled only in IDLE
i_stop  in  1  abort a running sequence
i_mode  in  2  pattern: 0 HOLD, 1 INC, 2 WALK, 3 LFSR
i_dwell  in  DWELL_W  each vector is held for i_dwell+1 cycles
i_count  in  CNT_W  number of vectors to emit; 0 means infinite
i_init  in  DATA_W  initial vector
o_sw_data  out  DATA_W  switch vector to the DUT
o_busy  out  1  high while in RUN
o_done  out  1  one-cycle pulse on normal completion
o_update  out  1  one-cycle pulse, coincident with each newly loaded vector
o_vec_cnt  out  CNT_W  vectors emitted in the current run

Behaviour:
- One clock domain. Reset is synchronous and active-high; the clock and reset ports are i_clk and i_reset.
- Reset values: state IDLE; o_sw_data=0, o_busy=0, o_done=0, o_update=0, o_vec_cnt=0, dwell counter=0. Reset has priority over everything, including mid-run.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - i_start=1 latches mode, dwell and count.
  - Next cycle: o_sw_data = first vector, o_vec_cnt=1, o_update=1, o_busy=1, dwell counter = i_dwell, state RUN.
  - i_stop is ignored in IDLE.
- First vector by mode:
  - HOLD and INC: i_init.
  - WALK: i_init if it is one-hot, else 1.
  - LFSR: i_init if nonzero, else LFSR_SEED.
- RUN, each cycle:
  - i_stop=1: go to IDLE next cycle, o_busy=0, no o_done, o_sw_data holds. i_stop takes priority over advance and completion in the same cycle.
  - Else if dwell counter != 0: decrement it.
  - Else if count != 0 and o_vec_cnt == count: go to DONE.
  - Else advance the vector, assert o_update, reload the dwell counter, and increment o_vec_cnt (saturating at all-ones; the run continues).
- Advance rules:
  - HOLD: vector unchanged, but o_update and o_vec_cnt still advance.
  - INC: +1 modulo 2^DATA_W (all-ones wraps to 0).
  - WALK: rotate left by 1 (MSB wraps to bit 0).
  - LFSR: Galois right shift, v = (v>>1) ^ (v[0] ? LFSR_TAPS : 0).
- DONE: o_done=1 and o_busy=0 for exactly one cycle, then IDLE. o_sw_data and o_vec_cnt hold until the next start.
- i_start while in RUN or DONE is ignored. Input changes while running have no effect, because values are latched at start.
- Timing: a vector is stable for exactly i_dwell+1 cycles. A run of N vectors has o_busy high for N*(i_dwell+1) cycles, followed by o_done.

Test Plan:
- Reset, then idle 5 cycles -> o_sw_data=0, o_busy=0, o_done=0, o_update=0, o_vec_cnt=0 throughout.
- INC: init=5, dwell=2, count=4, pulse start -> o_sw_data sequence 5,6,7,8, each held 3 cycles; 4 o_update pulses; o_busy high 12 cycles; o_done pulses once; final o_sw_data=8, o_vec_cnt=4.
- INC wrap: init=0xFFFF_FFFE, dwell=0, count=3 -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on consecutive cycles; o_update high 3 consecutive cycles.
- WALK: init=0x3 (not one-hot), dwell=0, count=33 -> 0x1, 0x2, …, 0x8000_0000, then 0x1 again on the 33rd vector.
- LFSR: init=0, dwell=0, count=2 -> 0xACE1_0001, then 0xD650_8003.
- Control:
  - count=0 (infinite), assert i_stop after 10 vectors -> o_busy drops, no o_done, o_sw_data holds.
  - i_start during RUN is ignored.
  - i_reset during RUN -> all outputs return to reset values next cycle.
